// File: rtl/request_latch.sv
// request_latch
//
// Clocked button-request block for the elevator controller. Every cabin and
// hall button is synchronised, debounced and turned into a single press
// event. Each press latches a request bit. The bit stays set until the
// motion/door controller clears it through the matching inactivate vector.
//
// The block also reports:
//   - whether requests are pending at, above or below the cabin position
//   - the total number of pending requests
//   - a one-cycle pulse whenever a new request is registered
//
// Ports
//   clk                        system clock, rising edge
//   reset                      asynchronous, active-low reset
//   btn_in                     raw cabin buttons, one per level
//   btn_up_out                 raw hall "up" buttons, one per level
//   btn_down_out               raw hall "down" buttons, one per level
//   inactivate_in_levels       synchronous clear of cabin requests
//   inactivate_out_up_levels   synchronous clear of hall "up" requests
//   inactivate_out_down_levels synchronous clear of hall "down" requests
//   current_level              cabin floor, synchronous to clk
//   active_in_levels           latched cabin requests
//   active_out_up_levels       latched hall "up" requests (top level is always 0)
//   active_out_down_levels     latched hall "down" requests (bottom level is always 0)
//   request_here               a request is pending at current_level
//   request_above              a request is pending above current_level
//   request_below              a request is pending below current_level
//   pending_count              number of latched requests
//   new_request                one-cycle pulse after a request bit is newly set

module request_latch #(
    parameter int LEVELS   = 8,
    parameter int LEVEL_W  = 3,
    parameter int DEBOUNCE = 4,
    parameter int CNT_W    = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [LEVELS-1:0]  btn_in,
    input  logic [LEVELS-1:0]  btn_up_out,
    input  logic [LEVELS-1:0]  btn_down_out,
    input  logic [LEVELS-1:0]  inactivate_in_levels,
    input  logic [LEVELS-1:0]  inactivate_out_up_levels,
    input  logic [LEVELS-1:0]  inactivate_out_down_levels,
    input  logic [LEVEL_W-1:0] current_level,
    output logic [LEVELS-1:0]  active_in_levels,
    output logic [LEVELS-1:0]  active_out_up_levels,
    output logic [LEVELS-1:0]  active_out_down_levels,
    output logic               request_here,
    output logic               request_above,
    output logic               request_below,
    output logic [CNT_W-1:0]   pending_count,
    output logic               new_request
);

    // All three button groups are handled as one flat vector:
    // bits [LEVELS-1:0] are the cabin buttons, the next LEVELS bits are
    // hall up, and the top LEVELS bits are hall down.
    localparam int         N       = 3 * LEVELS;
    localparam logic [3:0] DB_LAST = 4'(DEBOUNCE - 1);

    logic [N-1:0]     raw;
    logic [N-1:0]     clr;
    logic [N-1:0]     keep;
    logic [N-1:0]     sync_q;
    logic [N-1:0]     s_q;
    logic [N-1:0]     f_q;
    logic [N-1:0]     f_dly_q;
    logic [3:0]       cnt_q [N];
    logic [N-1:0]     press;
    logic [N-1:0]     act_q;
    logic [N-1:0]     act_nxt;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_nxt;
    logic             rose_q;
    logic             new_request_q;
    int               cur_idx;
    logic             level_any;

    assign raw = {btn_down_out, btn_up_out, btn_in};
    assign clr = {inactivate_out_down_levels, inactivate_out_up_levels, inactivate_in_levels};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            s_q    <= '0;
        end else begin
            sync_q <= raw;
            s_q    <= sync_q;
        end
    end

    // The counter only advances while the synchronised input disagrees with
    // the filtered level. Any sample that agrees again restarts it, so short
    // glitches never reach the filtered level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            f_q     <= '0;
            f_dly_q <= '0;
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            f_dly_q <= f_q;
            for (int i = 0; i < N; i++) begin
                if (s_q[i] == f_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == DB_LAST) begin
                    f_q[i]   <= s_q[i];
                    cnt_q[i] <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 4'd1;
                end
            end
        end
    end

    // A press exists only on the single cycle where the filtered level rises.
    // A clear in that same cycle therefore consumes the press for good.
    // Hall up on the top floor and hall down on the bottom floor can never latch.
    always_comb begin
        keep                = '1;
        keep[2*LEVELS-1]    = 1'b0;
        keep[2*LEVELS]      = 1'b0;
        press               = f_q & ~f_dly_q;
        act_nxt             = (act_q | press) & ~clr & keep;
        count_nxt           = '0;
        for (int i = 0; i < N; i++) begin
            count_nxt = count_nxt + CNT_W'(act_nxt[i]);
        end
    end

    // new_request is delayed one stage behind the rise of an active bit, so
    // it fires on the edge after the bit becomes visible.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            act_q         <= '0;
            count_q       <= '0;
            rose_q        <= 1'b0;
            new_request_q <= 1'b0;
        end else begin
            act_q         <= act_nxt;
            count_q       <= count_nxt;
            rose_q        <= |(act_nxt & ~act_q);
            new_request_q <= rose_q;
        end
    end

    always_comb begin
        request_here  = 1'b0;
        request_above = 1'b0;
        request_below = 1'b0;
        level_any     = 1'b0;
        cur_idx       = int'(current_level);
        if (cur_idx < LEVELS) begin
            for (int i = 0; i < LEVELS; i++) begin
                level_any = act_q[i] | act_q[LEVELS+i] | act_q[2*LEVELS+i];
                if (i == cur_idx) begin
                    request_here = request_here | level_any;
                end else if (i > cur_idx) begin
                    request_above = request_above | level_any;
                end else begin
                    request_below = request_below | level_any;
                end
            end
        end
    end

    assign active_in_levels       = act_q[LEVELS-1:0];
    assign active_out_up_levels   = act_q[2*LEVELS-1:LEVELS];
    assign active_out_down_levels = act_q[3*LEVELS-1:2*LEVELS];
    assign pending_count          = count_q;
    assign new_request            = new_request_q;

endmodule

// File: tb/tb_request_latch.sv
// tb_request_latch
//
// Directed bench for request_latch with LEVELS=8, DEBOUNCE=4.
// Expected values are queued at the point the stimulus is applied, and each
// check pops the next expectation and compares it against the DUT output.
// Inputs are driven, and outputs sampled, on the falling clock edge.

module tb_request_latch;

    localparam int LEVELS   = 8;
    localparam int LEVEL_W  = 3;
    localparam int DEBOUNCE = 4;
    localparam int CNT_W    = 5;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic [LEVELS-1:0]  btn_in = '0;
    logic [LEVELS-1:0]  btn_up_out = '0;
    logic [LEVELS-1:0]  btn_down_out = '0;
    logic [LEVELS-1:0]  inactivate_in_levels = '0;
    logic [LEVELS-1:0]  inactivate_out_up_levels = '0;
    logic [LEVELS-1:0]  inactivate_out_down_levels = '0;
    logic [LEVEL_W-1:0] current_level = '0;
    logic [LEVELS-1:0]  active_in_levels;
    logic [LEVELS-1:0]  active_out_up_levels;
    logic [LEVELS-1:0]  active_out_down_levels;
    logic               request_here;
    logic               request_above;
    logic               request_below;
    logic [CNT_W-1:0]   pending_count;
    logic               new_request;

    int          compared = 0;
    int          mismatched = 0;
    int          pulse_count = 0;
    int          pulse_base = 0;
    string       tag_q[$];
    logic [31:0] exp_q[$];

    request_latch #(
        .LEVELS  (LEVELS),
        .LEVEL_W (LEVEL_W),
        .DEBOUNCE(DEBOUNCE),
        .CNT_W   (CNT_W)
    ) dut (
        .clk                       (clk),
        .reset                     (reset),
        .btn_in                    (btn_in),
        .btn_up_out                (btn_up_out),
        .btn_down_out              (btn_down_out),
        .inactivate_in_levels      (inactivate_in_levels),
        .inactivate_out_up_levels  (inactivate_out_up_levels),
        .inactivate_out_down_levels(inactivate_out_down_levels),
        .current_level             (current_level),
        .active_in_levels          (active_in_levels),
        .active_out_up_levels      (active_out_up_levels),
        .active_out_down_levels    (active_out_down_levels),
        .request_here              (request_here),
        .request_above             (request_above),
        .request_below             (request_below),
        .pending_count             (pending_count),
        .new_request               (new_request)
    );

    always #5 clk = ~clk;

    // Counts pulses shortly after each rising edge, clear of the falling-edge checks.
    always @(posedge clk) begin
        #2;
        if (new_request === 1'b1) pulse_count++;
    end

    task automatic expect_value(input string tag, input logic [31:0] value);
        tag_q.push_back(tag);
        exp_q.push_back(value);
    endtask

    task automatic check_output(input logic [31:0] observed);
        string       tag;
        logic [31:0] expected;
        compared++;
        if (exp_q.size() == 0) begin
            mismatched++;
            $error("[TB] FAIL scoreboard_empty observed=0x%0h expected=<none>", observed);
        end else begin
            tag      = tag_q.pop_front();
            expected = exp_q.pop_front();
            assert (observed === expected) else begin
                mismatched++;
                $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
            end
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apply_stimulus(input logic [LEVELS-1:0] cab,
                                  input logic [LEVELS-1:0] up,
                                  input logic [LEVELS-1:0] down);
        btn_in       = cab;
        btn_up_out   = up;
        btn_down_out = down;
    endtask

    task automatic pulse_clear(input logic [LEVELS-1:0] cab,
                               input logic [LEVELS-1:0] up,
                               input logic [LEVELS-1:0] down);
        inactivate_in_levels       = cab;
        inactivate_out_up_levels   = up;
        inactivate_out_down_levels = down;
        wait_cycles(1);
        inactivate_in_levels       = '0;
        inactivate_out_up_levels   = '0;
        inactivate_out_down_levels = '0;
    endtask

    function automatic logic [31:0] flags();
        return {29'd0, request_here, request_above, request_below};
    endfunction

    initial begin
        // Reset state
        wait_cycles(2);
        expect_value("rst_active_in", 32'h0);
        expect_value("rst_active_up", 32'h0);
        expect_value("rst_active_down", 32'h0);
        expect_value("rst_pending", 32'h0);
        expect_value("rst_new_request", 32'h0);
        check_output(32'(active_in_levels));
        check_output(32'(active_out_up_levels));
        check_output(32'(active_out_down_levels));
        check_output(32'(pending_count));
        check_output(32'(new_request));
        reset = 1'b1;
        wait_cycles(3);

        // Single hall-up press at level 4, cabin at level 0
        $display("[TB] single press latency");
        pulse_base = pulse_count;
        apply_stimulus('0, 8'h10, '0);
        expect_value("t1_up_before_latch", 32'h0);
        expect_value("t1_up_latched", 32'h10);
        expect_value("t1_pending", 32'd1);
        expect_value("t1_flags", 32'b010);
        expect_value("t1_pulse_not_yet", 32'h0);
        expect_value("t1_pulse_high", 32'h1);
        expect_value("t1_pulse_low", 32'h0);
        expect_value("t1_pulse_total", 32'(pulse_base + 1));
        expect_value("t1_release_holds", 32'h10);
        wait_cycles(6);
        check_output(32'(active_out_up_levels));
        wait_cycles(1);
        check_output(32'(active_out_up_levels));
        check_output(32'(pending_count));
        check_output(flags());
        check_output(32'(new_request));
        wait_cycles(1);
        check_output(32'(new_request));
        wait_cycles(1);
        check_output(32'(new_request));
        wait_cycles(3);
        check_output(32'(pulse_count));
        apply_stimulus('0, '0, '0);
        wait_cycles(10);
        check_output(32'(active_out_up_levels));

        pulse_clear('0, 8'h10, '0);
        expect_value("t1_clear_pending", 32'd0);
        expect_value("t1_clear_flags", 32'b000);
        check_output(32'(pending_count));
        check_output(flags());

        // Glitch shorter than the debounce window
        $display("[TB] glitch rejection");
        pulse_base = pulse_count;
        apply_stimulus(8'h42, '0, '0);
        wait_cycles(3);
        apply_stimulus('0, '0, '0);
        expect_value("t2_active_in", 32'h0);
        expect_value("t2_pending", 32'd0);
        expect_value("t2_pulses", 32'(pulse_base));
        wait_cycles(12);
        check_output(32'(active_in_levels));
        check_output(32'(pending_count));
        check_output(32'(pulse_count));

        // Three simultaneous presses, cabin at level 3
        $display("[TB] simultaneous presses");
        current_level = 3'd3;
        pulse_base = pulse_count;
        apply_stimulus(8'h42, '0, 8'h80);
        expect_value("t3_in_before_latch", 32'h0);
        expect_value("t3_in_latched", 32'h42);
        expect_value("t3_down_latched", 32'h80);
        expect_value("t3_pending", 32'd3);
        expect_value("t3_flags", 32'b011);
        expect_value("t3_pulse_high", 32'h1);
        expect_value("t3_pulse_low", 32'h0);
        expect_value("t3_pulse_total", 32'(pulse_base + 1));
        wait_cycles(6);
        check_output(32'(active_in_levels));
        wait_cycles(1);
        check_output(32'(active_in_levels));
        check_output(32'(active_out_down_levels));
        check_output(32'(pending_count));
        check_output(flags());
        wait_cycles(1);
        check_output(32'(new_request));
        wait_cycles(1);
        check_output(32'(new_request));
        apply_stimulus('0, '0, '0);
        wait_cycles(10);
        check_output(32'(pulse_count));
        pulse_clear(8'h42, '0, 8'h80);
        expect_value("t3_clear_pending", 32'd0);
        check_output(32'(pending_count));

        // Clear on the latch edge consumes the press
        $display("[TB] clear wins over press");
        current_level = 3'd0;
        pulse_base = pulse_count;
        apply_stimulus(8'h40, '0, '0);
        expect_value("t4_cleared_on_latch", 32'h0);
        expect_value("t4_held_no_retrigger", 32'h0);
        expect_value("t4_no_pulse", 32'(pulse_base));
        wait_cycles(6);
        pulse_clear(8'h40, '0, '0);
        check_output(32'(active_in_levels));
        wait_cycles(5);
        check_output(32'(active_in_levels));
        check_output(32'(pulse_count));
        apply_stimulus('0, '0, '0);
        wait_cycles(10);
        apply_stimulus(8'h40, '0, '0);
        expect_value("t4_repress_latched", 32'h40);
        expect_value("t4_repress_pulse", 32'(pulse_base + 1));
        wait_cycles(7);
        check_output(32'(active_in_levels));
        wait_cycles(3);
        check_output(32'(pulse_count));
        apply_stimulus('0, '0, '0);
        wait_cycles(10);
        pulse_clear(8'h40, '0, '0);

        // Masked buttons: up at the top floor, down at the bottom floor
        $display("[TB] masked buttons");
        pulse_base = pulse_count;
        apply_stimulus('0, 8'h80, 8'h01);
        expect_value("t5_up_masked", 32'h0);
        expect_value("t5_down_masked", 32'h0);
        expect_value("t5_pending", 32'd0);
        expect_value("t5_no_pulse", 32'(pulse_base));
        wait_cycles(12);
        check_output(32'(active_out_up_levels));
        check_output(32'(active_out_down_levels));
        check_output(32'(pending_count));
        check_output(32'(pulse_count));
        apply_stimulus('0, '0, '0);
        wait_cycles(10);

        // Reset mid-operation with a button held through it
        $display("[TB] reset with held button");
        apply_stimulus(8'h04, 8'h08, 8'h20);
        wait_cycles(10);
        apply_stimulus('0, '0, '0);
        wait_cycles(10);
        expect_value("t6_pending_before", 32'd3);
        check_output(32'(pending_count));
        apply_stimulus('0, '0, 8'h40);
        wait_cycles(2);
        reset = 1'b0;
        #1;
        expect_value("t6_rst_in", 32'h0);
        expect_value("t6_rst_up", 32'h0);
        expect_value("t6_rst_down", 32'h0);
        expect_value("t6_rst_pending", 32'd0);
        expect_value("t6_rst_flags", 32'b000);
        expect_value("t6_rst_pulse", 32'h0);
        check_output(32'(active_in_levels));
        check_output(32'(active_out_up_levels));
        check_output(32'(active_out_down_levels));
        check_output(32'(pending_count));
        check_output(flags());
        check_output(32'(new_request));
        wait_cycles(1);
        reset = 1'b1;
        expect_value("t6_down_before_latch", 32'h0);
        expect_value("t6_down_latched", 32'h40);
        expect_value("t6_pending_after", 32'd1);
        expect_value("t6_pulse_high", 32'h1);
        wait_cycles(6);
        check_output(32'(active_out_down_levels));
        wait_cycles(1);
        check_output(32'(active_out_down_levels));
        check_output(32'(pending_count));
        wait_cycles(1);
        check_output(32'(new_request));
        apply_stimulus('0, '0, '0);
        wait_cycles(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/request_latch.md
# request_latch

Parametrised, clocked successor to the combinational button-request block of the elevator controller. Per level, it synchronises and debounces the cabin (`btn_in`) and hall (`btn_up_out`, `btn_down_out`) buttons and latches one request per rising press. Requests are held until the controller clears them with the `inactivate_*` vectors. Per cycle it also reports, relative to the cabin position, whether requests are pending here, above or below, the number of pending requests, and a pulse whenever a new request is registered. It sits between the button I/O and the elevator motion/door state machine.

## Interface
- `LEVELS`, 8, number of floors; index 0 is the bottom floor.
- `LEVEL_W`, 3, width of `current_level`; must be at least clog2(`LEVELS`).
- `DEBOUNCE`, 4, consecutive stable cycles required to accept an input change; range 1..15.
- `CNT_W`, 5, width of `pending_count`; must be at least clog2(3*`LEVELS`+1).

Ports:
- `clk`  in  1  single system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `btn_in`, `btn_up_out`, `btn_down_out`  in  LEVELS each  raw, asynchronous button levels.
- `inactivate_in_levels`, `inactivate_out_up_levels`, `inactivate_out_down_levels`  in  LEVELS each  synchronous clear requests, one per bit.
- `current_level`  in  LEVEL_W  cabin floor, synchronous to `clk`.
- `active_in_levels`, `active_out_up_levels`, `active_out_down_levels`  out  LEVELS each  latched requests.
- `request_here`, `request_above`, `request_below`  out  1 each  request position relative to `current_level`.
- `pending_count`  out  CNT_W  number of set bits across the three active vectors.
- `new_request`  out  1  one-cycle pulse when at least one request bit was newly set.

## Operation
- Reset value: while `reset`=0, every flop is 0 (synchronisers, debounce counters, filtered levels, active vectors, `pending_count`, `new_request`). All outputs therefore read 0.
- Synchroniser: each of the 3*`LEVELS` inputs passes through a 2-flop synchroniser. The second stage is called `s`.
- Debounce, per bit:
  - Keep a filtered level `f` and a counter `c`.
  - If `s`==`f`, `c` is set to 0.
  - If `s`!=`f` and `c`==`DEBOUNCE`-1, `f` is set to `s` and `c` is set to 0.
  - Otherwise, `c` is incremented.
  - A glitch shorter than `DEBOUNCE` consecutive samples is never accepted.
- Press event: a press is the 0→1 transition of `f`. Holding a button produces exactly one press. A new press requires a debounced release followed by another debounced press.
- Latch, per bit, evaluated at each edge in this priority order:
  1. Inactivate bit = 1: active bit cleared. Clear wins over a same-cycle press, and that press is consumed (no retrigger later).
  2. Press event: active bit set.
  3. Otherwise: active bit holds.
- Masking: `active_out_up_levels[LEVELS-1]` and `active_out_down_levels[0]` are tied to 0. Presses on those buttons are ignored and do not pulse `new_request`.
- Position flags are combinational from the active registers and `current_level`:
  - `request_here`: any active bit of any vector at index `current_level`.
  - `request_above`: any active bit at an index greater than `current_level`.
  - `request_below`: any active bit at an index less than `current_level`.
  - If `current_level` >= `LEVELS`, all three flags are 0.
- `pending_count` is registered. It is computed from the next-state active vectors, so it updates on the same edge as those vectors. Its maximum value is 3*`LEVELS`-2.
- `new_request` is registered. It is 1 for exactly one cycle, on the edge after any active bit goes 0→1.
- Reset mid-operation: everything clears immediately. A button held through reset release registers as a fresh press after the normal latency.

## Timing
- Let E0 be the first edge that samples a raw input at 1, with the input held for `DEBOUNCE` consecutive samples.
  - `s` goes to 1 at E1.
  - `f` goes to 1 at E1+`DEBOUNCE`.
  - The active bit and `pending_count` update at E0+`DEBOUNCE`+2.
  - `new_request` is high from E0+`DEBOUNCE`+3 for one cycle.
- Clear latency: an inactivate bit sampled at edge E clears the active bit and decrements `pending_count` at E. The position flags follow combinationally.
- Release latency is symmetric: `f` goes to 0 `DEBOUNCE`+1 edges after the first edge that samples 0. Release has no effect on the active bits.
- Simultaneous presses on several bits in one cycle: all are latched on the same edge, `pending_count` rises by the number of bits, and a single `new_request` pulse is produced.

## Test plan
- Reset release, then `btn_up_out[4]`=1 held for 8 cycles, `DEBOUNCE`=4, `current_level`=0 → `active_out_up_levels`=0x10 exactly 6 edges after first sample; `pending_count`=1; `request_above`=1; `request_here`=0; `new_request` pulses once.
- `btn_in[1]` and `btn_in[6]` pulsed high for 3 cycles (shorter than `DEBOUNCE`) → no active bits, `pending_count`=0, no pulse.
- `btn_in[1]`, `btn_in[6]` and `btn_down_out[7]` rising in the same cycle → all three latched on one edge; `pending_count`=3; single `new_request` pulse; `current_level`=3 gives `request_above`=1 and `request_below`=1.
- `inactivate_in_levels[6]`=1 asserted in the same cycle as `btn_in[6]`'s latch edge, button held afterwards → bit 6 stays 0 and no `new_request`; after release and a re-press it sets normally.
- Presses on `btn_up_out[7]` and `btn_down_out[0]` → both outputs remain 0, `pending_count` unchanged, no pulse.
- `reset`=0 for one cycle with 3 requests pending while `btn_down_out[6]` is held → all outputs 0 immediately; after release, `active_out_down_levels`=0x40 at `DEBOUNCE`+2 edges.
